// File: rtl/skolem_exhaustive_checker_if.sv
// Vector/candidate link between the exhaustive checker (master) and the Skolem block (slave).
interface skolem_exhaustive_checker_if #(
  parameter int W = 4
);
  logic [2*W-1:0] sk_in;
  logic [W-1:0]   sk_out;

  modport master (output sk_in, input sk_out);
  modport slave  (input sk_in, output sk_out);
endinterface

// File: rtl/skolem_exhaustive_checker.sv
// Exhaustive sweep harness for the W-bit bvsge/bvashr Skolem block: drives every (s, t),
// checks the returned candidate and, when it fails, searches for any witness x.
module skolem_exhaustive_checker #(
  parameter int W      = 4,
  parameter int SK_LAT = 1
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_start,
  skolem_exhaustive_checker_if.master sk_bus,
  output logic                        o_busy,
  output logic                        o_done,
  output logic                        o_pass,
  output logic [2*W:0]                o_fail_count,
  output logic [2*W:0]                o_vac_count,
  output logic                        o_first_fail_valid,
  output logic [2*W-1:0]              o_first_fail_vec
);

  localparam int LW = (SK_LAT > 1) ? $clog2(SK_LAT) : 1;
  localparam logic [LW-1:0]  LAT_LAST = LW'(SK_LAT - 1);
  localparam logic [LW-1:0]  LAT_ONE  = LW'(1);
  localparam logic [W-1:0]   Y_LAST   = {W{1'b1}};
  localparam logic [W-1:0]   Y_ONE    = W'(1);
  localparam logic [2*W-1:0] VEC_LAST = {(2*W){1'b1}};
  localparam logic [2*W-1:0] VEC_ONE  = (2*W)'(1);
  localparam logic [2*W:0]   CNT_ONE  = (2*W+1)'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_APPLY  = 3'd1,
    S_CHECK  = 3'd2,
    S_SEARCH = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [LW-1:0]    r_lat_cnt, w_lat_nxt;
  logic [2*W-1:0]   r_vec_cnt, w_vec_nxt;
  logic [W-1:0]     r_x, w_x_nxt;
  logic [W-1:0]     r_y_cnt, w_y_nxt;
  logic [2*W:0]     r_fail_cnt, w_fail_nxt;
  logic [2*W:0]     r_vac_cnt, w_vac_nxt;
  logic             r_ff_valid, w_ff_valid_nxt;
  logic [2*W-1:0]   r_ff_vec, w_ff_vec_nxt;
  logic             r_pass, w_pass_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_done, w_done_nxt;
  logic             w_advance;
  logic [W-1:0]     w_s, w_t;

  // Shift amounts of W or more saturate to a full sign fill.
  function automatic logic f_sat(input logic [W-1:0] x, input logic [W-1:0] s,
                                 input logic [W-1:0] t);
    logic [W-1:0] r;
    if (32'(s) >= W) begin
      r = {W{x[W-1]}};
    end else begin
      r = $signed(x) >>> s;
    end
    return $signed(r) >= $signed(t);
  endfunction

  assign w_s = r_vec_cnt[W-1:0];
  assign w_t = r_vec_cnt[2*W-1:W];

  // Next-state and datapath update for the sweep FSM.
  always_comb begin
    w_state_nxt    = r_state;
    w_lat_nxt      = r_lat_cnt;
    w_vec_nxt      = r_vec_cnt;
    w_x_nxt        = r_x;
    w_y_nxt        = r_y_cnt;
    w_fail_nxt     = r_fail_cnt;
    w_vac_nxt      = r_vac_cnt;
    w_ff_valid_nxt = r_ff_valid;
    w_ff_vec_nxt   = r_ff_vec;
    w_pass_nxt     = r_pass;
    w_advance      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_vec_nxt      = '0;
          w_fail_nxt     = '0;
          w_vac_nxt      = '0;
          w_ff_valid_nxt = 1'b0;
          w_ff_vec_nxt   = '0;
          w_pass_nxt     = 1'b0;
          w_lat_nxt      = '0;
          w_state_nxt    = S_APPLY;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_APPLY: begin
        if (r_lat_cnt == LAT_LAST) begin
          w_x_nxt     = sk_bus.sk_out;
          w_state_nxt = S_CHECK;
        end else begin
          w_lat_nxt = r_lat_cnt + LAT_ONE;
        end
      end
      S_CHECK: begin
        if (f_sat(r_x, w_s, w_t)) begin
          w_advance = 1'b1;
        end else begin
          w_y_nxt     = '0;
          w_state_nxt = S_SEARCH;
        end
      end
      S_SEARCH: begin
        if (f_sat(r_y_cnt, w_s, w_t)) begin
          w_fail_nxt = r_fail_cnt + CNT_ONE;
          if (!r_ff_valid) begin
            w_ff_valid_nxt = 1'b1;
            w_ff_vec_nxt   = r_vec_cnt;
          end else begin
            w_ff_valid_nxt = r_ff_valid;
          end
          w_advance = 1'b1;
        end else if (r_y_cnt == Y_LAST) begin
          w_vac_nxt = r_vac_cnt + CNT_ONE;
          w_advance = 1'b1;
        end else begin
          w_y_nxt = r_y_cnt + Y_ONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    // pass must reflect the increment made by the very last vector.
    if (w_advance) begin
      if (r_vec_cnt == VEC_LAST) begin
        w_state_nxt = S_DONE;
        w_pass_nxt  = (w_fail_nxt == '0);
      end else begin
        w_vec_nxt   = r_vec_cnt + VEC_ONE;
        w_lat_nxt   = '0;
        w_state_nxt = S_APPLY;
      end
    end else begin
      w_pass_nxt = w_pass_nxt;
    end
  end

  assign w_busy_nxt = (w_state_nxt == S_APPLY) || (w_state_nxt == S_CHECK) ||
                      (w_state_nxt == S_SEARCH);
  assign w_done_nxt = (w_state_nxt == S_DONE);

  // State and datapath registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= S_IDLE;
      r_lat_cnt  <= '0;
      r_vec_cnt  <= '0;
      r_x        <= '0;
      r_y_cnt    <= '0;
      r_fail_cnt <= '0;
      r_vac_cnt  <= '0;
      r_ff_valid <= 1'b0;
      r_ff_vec   <= '0;
      r_pass     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_lat_cnt  <= w_lat_nxt;
      r_vec_cnt  <= w_vec_nxt;
      r_x        <= w_x_nxt;
      r_y_cnt    <= w_y_nxt;
      r_fail_cnt <= w_fail_nxt;
      r_vac_cnt  <= w_vac_nxt;
      r_ff_valid <= w_ff_valid_nxt;
      r_ff_vec   <= w_ff_vec_nxt;
      r_pass     <= w_pass_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
    end
  end

  assign sk_bus.sk_in       = r_vec_cnt;
  assign o_busy             = r_busy;
  assign o_done             = r_done;
  assign o_pass             = r_pass;
  assign o_fail_count       = r_fail_cnt;
  assign o_vac_count        = r_vac_cnt;
  assign o_first_fail_valid = r_ff_valid;
  assign o_first_fail_vec   = r_ff_vec;

endmodule

// File: tb/tb_skolem_exhaustive_checker.sv
// Directed bench: two checker instances (latency 1 and 3) driven by bench-side Skolem models.
module tb_skolem_exhaustive_checker;

  logic clk = 1'b0;
  logic rst_n;
  logic start1, start3;
  logic [1:0] mode;

  logic       busy1, done1, pass1, ffv1;
  logic [8:0] fail1, vac1;
  logic [7:0] ffvec1;
  logic       busy3, done3, pass3, ffv3;
  logic [8:0] fail3, vac3;
  logic [7:0] ffvec3;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt1 = 0;
  int run3 = 0, min3 = 0, chg3 = 0;
  logic [7:0] prev3 = 8'h00;
  logic was3 = 1'b0;

  always #5 clk = ~clk;

  skolem_exhaustive_checker_if #(.W(4)) u_if1 ();
  skolem_exhaustive_checker_if #(.W(4)) u_if3 ();

  // Smallest x in 0..15 with (x >>a s) >= t, or 0 when none exists.
  function automatic logic [3:0] f_exact(input logic [7:0] v);
    int s, t, xs, r;
    s = int'(v[3:0]);
    t = (v[7:4] >= 4'd8) ? int'(v[7:4]) - 16 : int'(v[7:4]);
    for (int x = 0; x < 16; x++) begin
      xs = (x >= 8) ? x - 16 : x;
      r = xs >>> s;
      if (r >= t) return 4'(x);
    end
    return 4'h0;
  endfunction

  assign u_if1.sk_out = (mode == 2'd0) ? f_exact(u_if1.sk_in) :
                        (mode == 2'd1) ? 4'h0 : 4'h7;
  assign u_if3.sk_out = 4'h7;

  skolem_exhaustive_checker #(.W(4), .SK_LAT(1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start1), .sk_bus(u_if1.master),
    .o_busy(busy1), .o_done(done1), .o_pass(pass1), .o_fail_count(fail1),
    .o_vac_count(vac1), .o_first_fail_valid(ffv1), .o_first_fail_vec(ffvec1)
  );

  skolem_exhaustive_checker #(.W(4), .SK_LAT(3)) u_dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start3), .sk_bus(u_if3.master),
    .o_busy(busy3), .o_done(done3), .o_pass(pass3), .o_fail_count(fail3),
    .o_vac_count(vac3), .o_first_fail_valid(ffv3), .o_first_fail_vec(ffvec3)
  );

  always @(negedge clk) begin
    if (done1) done_cnt1 <= done_cnt1 + 1;
  end

  // Shortest sk_in hold and number of sk_in changes during an instance-3 sweep.
  always @(negedge clk) begin
    if (busy3) begin
      if (!was3) begin
        run3 <= 1; min3 <= 1000; chg3 <= 0;
      end else if (u_if3.sk_in == prev3) begin
        run3 <= run3 + 1;
      end else begin
        if (run3 < min3) min3 <= run3;
        chg3 <= chg3 + 1;
        run3 <= 1;
      end
      prev3 <= u_if3.sk_in;
    end
    was3 <= busy3;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pulse start on instance 1 and count busy cycles until done (bounded).
  task automatic sweep1(output int cyc, output logic tmo);
    int k;
    cyc = 0;
    tmo = 1'b1;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    for (k = 0; k < 20000; k++) begin
      if (done1) begin
        tmo = 1'b0;
        break;
      end
      if (busy1) cyc++;
      @(negedge clk);
    end
  endtask

  task automatic chk_reset1(input string tag);
    chk({tag, "_busy"}, 32'(busy1), 32'd0);
    chk({tag, "_done"}, 32'(done1), 32'd0);
    chk({tag, "_pass"}, 32'(pass1), 32'd0);
    chk({tag, "_skin"}, 32'(u_if1.sk_in), 32'd0);
    chk({tag, "_fail"}, 32'(fail1), 32'd0);
    chk({tag, "_vac"}, 32'(vac1), 32'd0);
    chk({tag, "_ffv"}, 32'(ffv1), 32'd0);
    chk({tag, "_ffvec"}, 32'(ffvec1), 32'd0);
  endtask

  initial begin
    int cyc, k, d0;
    logic tmo;
    rst_n = 1'b0; start1 = 1'b0; start3 = 1'b0; mode = 2'd0;
    #12;
    chk_reset1("rst");
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Exact Skolem model: every candidate holds, 101 vacuous vectors.
    mode = 2'd0;
    sweep1(cyc, tmo);
    chk("exact_timeout", 32'(tmo), 32'd0);
    chk("exact_busy_at_done", 32'(busy1), 32'd0);
    chk("exact_pass", 32'(pass1), 32'd1);
    chk("exact_fail", 32'(fail1), 32'd0);
    chk("exact_vac", 32'(vac1), 32'd101);
    chk("exact_ffv", 32'(ffv1), 32'd0);
    chk("exact_cycles", 32'(cyc), 32'd2128);

    // Stub x=0: 11 failures, first at s=0 t=1.
    mode = 2'd1;
    sweep1(cyc, tmo);
    chk("zero_timeout", 32'(tmo), 32'd0);
    chk("zero_pass", 32'(pass1), 32'd0);
    chk("zero_fail", 32'(fail1), 32'd11);
    chk("zero_vac", 32'(vac1), 32'd101);
    chk("zero_ffv", 32'(ffv1), 32'd1);
    chk("zero_ffvec", 32'(ffvec1), 32'h10);
    chk("zero_cycles", 32'(cyc), 32'd2183);
    @(negedge clk);
    chk("zero_hold_fail", 32'(fail1), 32'd11);
    chk("zero_hold_pass", 32'(pass1), 32'd0);

    // Instance with SK_LAT=3 and x=7.
    cyc = 0; tmo = 1'b1;
    @(negedge clk); start3 = 1'b1;
    @(negedge clk); start3 = 1'b0;
    for (k = 0; k < 20000; k++) begin
      if (done3) begin
        tmo = 1'b0;
        break;
      end
      if (busy3) cyc++;
      @(negedge clk);
    end
    chk("lat3_timeout", 32'(tmo), 32'd0);
    chk("lat3_fail", 32'(fail3), 32'd0);
    chk("lat3_vac", 32'(vac3), 32'd101);
    chk("lat3_pass", 32'(pass3), 32'd1);
    chk("lat3_min_hold", 32'(min3), 32'd4);
    chk("lat3_changes", 32'(chg3), 32'd255);
    chk("lat3_cycles", 32'(cyc), 32'd2640);

    // Abort mid-sweep at vec 0x40.
    mode = 2'd1;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    tmo = 1'b1;
    for (k = 0; k < 5000; k++) begin
      if (u_if1.sk_in == 8'h40) begin
        tmo = 1'b0;
        break;
      end
      @(negedge clk);
    end
    chk("abort_reach_40", 32'(tmo), 32'd0);
    chk("abort_pre_fail", 32'(fail1), 32'd7);
    chk("abort_pre_vac", 32'(vac1), 32'd41);
    d0 = done_cnt1;
    #2 rst_n = 1'b0;
    #1 chk_reset1("abort");
    repeat (3) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt1), 32'(d0));
    rst_n = 1'b1;
    @(negedge clk);
    sweep1(cyc, tmo);
    chk("rerun_timeout", 32'(tmo), 32'd0);
    chk("rerun_fail", 32'(fail1), 32'd11);
    chk("rerun_vac", 32'(vac1), 32'd101);
    chk("rerun_ffvec", 32'(ffvec1), 32'h10);

    // start pulses while busy must be ignored.
    mode = 2'd0;
    repeat (2) @(negedge clk);
    d0 = done_cnt1;
    cyc = 0; tmo = 1'b1;
    @(negedge clk); start1 = 1'b1;
    @(negedge clk); start1 = 1'b0;
    for (k = 0; k < 20000; k++) begin
      if (done1) begin
        tmo = 1'b0;
        break;
      end
      if (busy1) cyc++;
      start1 = busy1 && ((k % 37) == 5);
      @(negedge clk);
    end
    start1 = 1'b0;
    repeat (4) @(negedge clk);
    chk("pulse_timeout", 32'(tmo), 32'd0);
    chk("pulse_cycles", 32'(cyc), 32'd2128);
    chk("pulse_done_once", 32'(done_cnt1), 32'(d0 + 1));
    chk("pulse_busy_after", 32'(busy1), 32'd0);
    chk("pulse_vac", 32'(vac1), 32'd101);

    // start held through DONE relaunches from the following IDLE cycle.
    mode = 2'd2;
    @(negedge clk); start1 = 1'b1;
    tmo = 1'b1;
    for (k = 0; k < 20000; k++) begin
      @(negedge clk);
      if (done1) begin
        tmo = 1'b0;
        break;
      end
    end
    chk("held_timeout", 32'(tmo), 32'd0);
    @(negedge clk);
    chk("held_idle_gap", 32'(busy1), 32'd0);
    @(negedge clk);
    chk("held_relaunch", 32'(busy1), 32'd1);
    start1 = 1'b0;
    tmo = 1'b1;
    for (k = 0; k < 20000; k++) begin
      @(negedge clk);
      if (done1) begin
        tmo = 1'b0;
        break;
      end
    end
    chk("held2_timeout", 32'(tmo), 32'd0);
    chk("held2_vac", 32'(vac1), 32'd101);
    chk("held2_pass", 32'(pass1), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/skolem_exhaustive_checker.md
# skolem_exhaustive_checker

Sequential self-checking harness for the 4-bit `bvsge`/`bvashr` Skolem function block. It sits directly upstream of the Skolem block and consumes its result. It enumerates every (s, t) input vector, drives it into the Skolem block, and captures the candidate x. It then checks that `(x >>a s) >=s t` holds whenever any x satisfies it, and reports failure, vacuous-vector and first-failure information.

## Interface
- `W`, default 4: operand width; the vector space is 2^(2W).
- `SK_LAT`, default 1: cycles from driving `sk_in` to sampling `sk_out`. Minimum 1.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `start` input 1: begin a full sweep; sampled only in IDLE.
- `sk_in` output 2W: vector to the Skolem block. `sk_in[W-1:0]` = s (shift amount, unsigned). `sk_in[2W-1:W]` = t (signed bound).
- `sk_out` input W: candidate x from the Skolem block.
- `busy` output 1: high from the cycle after an accepted `start` until DONE.
- `done` output 1: one-cycle pulse at the end of a sweep.
- `pass` output 1: valid from `done` until the next accepted `start`; 1 iff `fail_count` == 0.
- `fail_count` output 2W+1: number of solvable vectors where the candidate x failed.
- `vac_count` output 2W+1: number of vectors with no satisfying x.
- `first_fail_valid` output 1: set on the first failure of a sweep.
- `first_fail_vec` output 2W: `sk_in` value of the first failure.

## Operation
- States: IDLE, APPLY, CHECK, SEARCH, DONE.
- **IDLE**
  - On `start`=1: clear `vec_cnt`, `fail_count`, `vac_count`, `first_fail_valid`, `first_fail_vec` and `pass`.
  - Go to APPLY.
- **APPLY**
  - `sk_in` = `vec_cnt`.
  - Wait `SK_LAT` cycles, then sample `sk_out` into `x_reg`.
  - Go to CHECK.
- **CHECK**
  - Compute `r = x_reg >>a s`. For s ≥ W, every bit of r equals the sign bit of `x_reg`.
  - Compare r ≥ t as signed W-bit values.
  - If true: the vector is solvable and passes; advance.
  - If false: clear `y_cnt` and go to SEARCH.
- **SEARCH**
  - Each cycle evaluates y = `y_cnt` with the same predicate, in ascending order 0..2^W−1.
  - First hit: the vector is solvable and the candidate failed.
    - Increment `fail_count`.
    - If `first_fail_valid`=0, latch `first_fail_vec` = `vec_cnt` and set `first_fail_valid`.
    - Advance.
  - No hit after y = 2^W−1: increment `vac_count` and advance.
- **Advance**
  - If `vec_cnt` = 2^(2W)−1, go to DONE.
  - Otherwise increment `vec_cnt` and go to APPLY.
- **DONE**
  - `done`=1 and `pass` = (`fail_count` == 0) for one cycle.
  - Return to IDLE.
  - Counters, `first_fail_*` and `pass` hold their values until the next start.
- `start` is ignored while `busy`=1.
- The counters cannot overflow: the maximum count 2^(2W) fits in 2W+1 bits.

## Timing
- Reset values:
  - state IDLE, `busy`=0, `done`=0, `pass`=0.
  - `sk_in`=0, `fail_count`=0, `vac_count`=0.
  - `first_fail_valid`=0, `first_fail_vec`=0.
- `rst_n` low at any point, including mid-sweep, aborts immediately to the reset values. There is no `done` pulse for the aborted sweep.
- `busy` rises the cycle after `start` is sampled in IDLE.
- `sk_in` changes only on entry to APPLY and is stable for all `SK_LAT` cycles.
- Per-vector cost:
  - Candidate passes: `SK_LAT` + 1 cycles.
  - Candidate fails, solution at index k: `SK_LAT` + 1 + (k+1) cycles.
  - Vacuous vector: `SK_LAT` + 1 + 2^W cycles.
- The cycle after the final CHECK/SEARCH cycle is DONE: `done`=1 and `busy`=0 in that same cycle.
- A correct Skolem model with no vacuous vectors would take 2^(2W)·(`SK_LAT`+1) busy cycles.
- `start` held high through DONE launches a new sweep in the following IDLE cycle.

## Test plan
- Exact Skolem model (any satisfying x when one exists), W=4, `SK_LAT`=1:
  - `pass`=1, `fail_count`=0, `vac_count`=101, `first_fail_valid`=0.
- Stub with `sk_out` tied to 0:
  - `fail_count`=11 (s=0: t=1..7; s=1: t=1..3; s=2: t=1), `vac_count`=101.
  - `first_fail_vec`=0x10, `pass`=0.
- Stub with `sk_out`=4'h7, `SK_LAT`=3:
  - `fail_count`=0, `vac_count`=101, `pass`=1.
  - Verify `sk_in` holds for 3 cycles per vector.
- Deassert `rst_n` when `vec_cnt`=0x40:
  - All outputs return to reset values immediately, with no `done` pulse.
  - A new `start` completes with the same totals as an uninterrupted sweep.
- Pulse `start` repeatedly while `busy`:
  - No restart and counters unaffected.
  - `done` appears exactly once per accepted start.
